// File: rtl/substitution_layer_folded.sv
// Folded Ascon substitution layer (p_S) over the 5x64 state.
// SLICES_PER_CYCLE columns are pushed through S-boxes per clock, in place,
// so one full layer takes 64/SLICES_PER_CYCLE RUN cycles. A start/done
// handshake frames each layer; a DONE cycle can immediately accept the next
// state so back-to-back layers run without an IDLE bubble.

// Single 5-bit Ascon S-box lookup, input/output MSB is x0.
module substitution_table (
  input  logic [4:0] sboxIn,
  output logic [4:0] sboxOut
);

  // Pure table lookup
  always_comb begin
    sboxOut = 5'h00;
    case (sboxIn)
      5'h00: sboxOut = 5'h04;
      5'h01: sboxOut = 5'h0b;
      5'h02: sboxOut = 5'h1f;
      5'h03: sboxOut = 5'h14;
      5'h04: sboxOut = 5'h1a;
      5'h05: sboxOut = 5'h15;
      5'h06: sboxOut = 5'h09;
      5'h07: sboxOut = 5'h02;
      5'h08: sboxOut = 5'h1b;
      5'h09: sboxOut = 5'h05;
      5'h0a: sboxOut = 5'h08;
      5'h0b: sboxOut = 5'h12;
      5'h0c: sboxOut = 5'h1d;
      5'h0d: sboxOut = 5'h03;
      5'h0e: sboxOut = 5'h06;
      5'h0f: sboxOut = 5'h1c;
      5'h10: sboxOut = 5'h1e;
      5'h11: sboxOut = 5'h13;
      5'h12: sboxOut = 5'h07;
      5'h13: sboxOut = 5'h0e;
      5'h14: sboxOut = 5'h00;
      5'h15: sboxOut = 5'h0d;
      5'h16: sboxOut = 5'h11;
      5'h17: sboxOut = 5'h18;
      5'h18: sboxOut = 5'h10;
      5'h19: sboxOut = 5'h0c;
      5'h1a: sboxOut = 5'h01;
      5'h1b: sboxOut = 5'h19;
      5'h1c: sboxOut = 5'h16;
      5'h1d: sboxOut = 5'h0a;
      5'h1e: sboxOut = 5'h0f;
      5'h1f: sboxOut = 5'h17;
      default: sboxOut = 5'h00;
    endcase
  end

endmodule

module substitution_layer_folded #(
  parameter int SLICES_PER_CYCLE = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [4:0][63:0] registerS_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [4:0][63:0] registerS_o
);

  localparam int NB_STEPS = 64 / SLICES_PER_CYCLE;
  localparam int CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NB_STEPS - 1);

  // Column count must tile the 64-bit lanes exactly
  if ((SLICES_PER_CYCLE < 1) || (SLICES_PER_CYCLE > 64) ||
      ((64 % SLICES_PER_CYCLE) != 0)) begin : gBadSlices
    $error("SLICES_PER_CYCLE must divide 64");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  logic [CNT_W-1:0] counter;
  logic [4:0][63:0] workReg;
  logic             doneQ;
  logic             readyQ;

  logic [5:0] colIdx   [SLICES_PER_CYCLE];
  logic [4:0] sliceIn  [SLICES_PER_CYCLE];
  logic [4:0] sliceOut [SLICES_PER_CYCLE];

  // Gather the columns selected by the step counter into 5-bit S-box words
  always_comb begin
    for (int j = 0; j < SLICES_PER_CYCLE; j++) begin
      colIdx[j]  = 6'(int'(counter) * SLICES_PER_CYCLE + j);
      sliceIn[j] = {workReg[0][colIdx[j]], workReg[1][colIdx[j]],
                    workReg[2][colIdx[j]], workReg[3][colIdx[j]],
                    workReg[4][colIdx[j]]};
    end
  end

  for (genvar g = 0; g < SLICES_PER_CYCLE; g++) begin : gSbox
    substitution_table uSbox (
      .sboxIn  (sliceIn[g]),
      .sboxOut (sliceOut[g])
    );
  end

  // Control FSM and in-place working register; outputs are registered
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state   <= IDLE;
      counter <= '0;
      workReg <= '0;
      doneQ   <= 1'b0;
      readyQ  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          doneQ <= 1'b0;
          if (start_i) begin
            workReg <= registerS_i;
            counter <= '0;
            state   <= RUN;
            readyQ  <= 1'b0;
          end else begin
            readyQ  <= 1'b1;
          end
        end
        RUN: begin
          // Write substituted columns back; untouched columns hold
          for (int j = 0; j < SLICES_PER_CYCLE; j++) begin
            workReg[0][colIdx[j]] <= sliceOut[j][4];
            workReg[1][colIdx[j]] <= sliceOut[j][3];
            workReg[2][colIdx[j]] <= sliceOut[j][2];
            workReg[3][colIdx[j]] <= sliceOut[j][1];
            workReg[4][colIdx[j]] <= sliceOut[j][0];
          end
          if (counter == LAST_STEP) begin
            state  <= DONE;
            doneQ  <= 1'b1;
            readyQ <= 1'b1;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        DONE: begin
          doneQ <= 1'b0;
          if (start_i) begin
            workReg <= registerS_i;
            counter <= '0;
            state   <= RUN;
            readyQ  <= 1'b0;
          end else begin
            state   <= IDLE;
            readyQ  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
          doneQ   <= 1'b0;
          readyQ  <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o     = readyQ;
  assign done_o      = doneQ;
  assign registerS_o = workReg;

endmodule

// File: tb/tb_substitution_layer_folded.sv
// Bench for substitution_layer_folded: directed scenarios on an S=8
// instance plus random sweeps on S=1, S=8 and S=64 instances, all checked
// against a column-by-column table model of the Ascon S-box layer.
module tb_substitution_layer_folded;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             startV [3];
  logic [4:0][63:0] inV    [3];
  logic             readyV [3];
  logic             doneV  [3];
  logic [4:0][63:0] outV   [3];

  int total;
  int bad;

  localparam logic [4:0] SBOX_TABLE [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  // index 0: S=64 (1 step), index 1: S=8 (8 steps), index 2: S=1 (64 steps)
  substitution_layer_folded #(.SLICES_PER_CYCLE(64)) dut64 (
    .clock_i(clk), .reset_i(rst), .start_i(startV[0]), .registerS_i(inV[0]),
    .ready_o(readyV[0]), .done_o(doneV[0]), .registerS_o(outV[0]));
  substitution_layer_folded #(.SLICES_PER_CYCLE(8)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(startV[1]), .registerS_i(inV[1]),
    .ready_o(readyV[1]), .done_o(doneV[1]), .registerS_o(outV[1]));
  substitution_layer_folded #(.SLICES_PER_CYCLE(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(startV[2]), .registerS_i(inV[2]),
    .ready_o(readyV[2]), .done_o(doneV[2]), .registerS_o(outV[2]));

  function automatic logic [4:0][63:0] refLayer(input logic [4:0][63:0] s);
    logic [4:0][63:0] r;
    logic [4:0]       v;
    logic [5:0]       ci;
    r = '0;
    for (int c = 0; c < 64; c++) begin
      ci = 6'(c);
      v = SBOX_TABLE[{s[0][ci], s[1][ci], s[2][ci], s[3][ci], s[4][ci]}];
      r[0][ci] = v[4];
      r[1][ci] = v[3];
      r[2][ci] = v[2];
      r[3][ci] = v[1];
      r[4][ci] = v[0];
    end
    return r;
  endfunction

  function automatic logic [4:0][63:0] randState();
    logic [4:0][63:0] s;
    for (int r = 0; r < 5; r++) s[r] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start on instance k and wait (bounded) for done
  task automatic runOp(input int k, input logic [4:0][63:0] st,
                       output logic [4:0][63:0] res, output int lat, output bit ok);
    startV[k] = 1'b1;
    inV[k]    = st;
    tick();
    startV[k] = 1'b0;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 200) begin
      tick();
      lat++;
      if (doneV[k]) ok = 1'b1;
    end
    res = outV[k];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    startV[1] = 1'b1;
    inV[1] = {5{64'hFFFF_FFFF_FFFF_FFFF}};
    tick();
    tick();
    rst = 1'b0;
    startV[1] = 1'b0;
    total++;
    if (readyV[1] !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", readyV[1]); end
    total++;
    if (doneV[1] !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", doneV[1]); end
    total++;
    if (outV[1] !== '0) begin bad++; $display("FAIL reset_state got=%h want=0", outV[1]); end
    tick();
    total++;
    if (readyV[1] !== 1'b1 || outV[1] !== '0) begin
      bad++; $display("FAIL reset_idle ready=%b state=%h want ready=1 state=0", readyV[1], outV[1]);
    end
  endtask

  task automatic test_zero();
    logic [4:0][63:0] res; int lat; bit ok;
    logic [4:0][63:0] want;
    want = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
    runOp(1, '0, res, lat, ok);
    total++;
    if (!ok || res !== want) begin bad++; $display("FAIL zero_state ok=%0d got=%h want=%h", ok, res, want); end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL zero_latency got=%0d want=8", lat); end
  endtask

  task automatic test_ones();
    logic [4:0][63:0] res; int lat; bit ok;
    logic [4:0][63:0] want;
    want = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    tick();
    runOp(1, {5{64'hFFFF_FFFF_FFFF_FFFF}}, res, lat, ok);
    total++;
    if (!ok || res !== want) begin bad++; $display("FAIL ones_state ok=%0d got=%h want=%h", ok, res, want); end
  endtask

  task automatic test_latency();
    logic [4:0][63:0] st, want;
    tick();
    st = randState();
    want = refLayer(st);
    startV[1] = 1'b1;
    inV[1] = st;
    tick();
    startV[1] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) begin startV[1] = 1'b1; inV[1] = randState(); end
      if (c == 4) startV[1] = 1'b0;
      if (c < 8) begin
        total++;
        if (doneV[1] !== 1'b0 || readyV[1] !== 1'b0) begin
          bad++; $display("FAIL lat_run_cycle%0d done=%b ready=%b want done=0 ready=0", c, doneV[1], readyV[1]);
        end
      end else begin
        total++;
        if (doneV[1] !== 1'b1 || readyV[1] !== 1'b1) begin
          bad++; $display("FAIL lat_done done=%b ready=%b want done=1 ready=1", doneV[1], readyV[1]);
        end
        total++;
        if (outV[1] !== want) begin bad++; $display("FAIL lat_result got=%h want=%h", outV[1], want); end
      end
    end
    tick();
    total++;
    if (doneV[1] !== 1'b0 || readyV[1] !== 1'b1 || outV[1] !== want) begin
      bad++; $display("FAIL lat_after done=%b ready=%b state=%h want done=0 ready=1 state=%h", doneV[1], readyV[1], outV[1], want);
    end
    tick();
    total++;
    if (doneV[1] !== 1'b0 || outV[1] !== want) begin
      bad++; $display("FAIL lat_idle_hold done=%b state=%h want done=0 state=%h", doneV[1], outV[1], want);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0][63:0] a, b, res; int lat; bit ok;
    a = randState();
    b = randState();
    runOp(1, a, res, lat, ok);
    total++;
    if (!ok || res !== refLayer(a)) begin bad++; $display("FAIL b2b_first ok=%0d got=%h want=%h", ok, res, refLayer(a)); end
    total++;
    if (readyV[1] !== 1'b1) begin bad++; $display("FAIL b2b_ready_in_done got=%b want=1", readyV[1]); end
    runOp(1, b, res, lat, ok);
    total++;
    if (!ok || lat + 1 !== 9) begin bad++; $display("FAIL b2b_gap ok=%0d got=%0d want=9", ok, lat + 1); end
    total++;
    if (res !== refLayer(b)) begin bad++; $display("FAIL b2b_second got=%h want=%h", res, refLayer(b)); end
  endtask

  task automatic test_reset_mid();
    logic [4:0][63:0] st, res; int lat; bit ok; bit sawDone;
    tick();
    startV[1] = 1'b1;
    inV[1] = randState();
    tick();
    startV[1] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (readyV[1] !== 1'b1 || doneV[1] !== 1'b0 || outV[1] !== '0) begin
      bad++; $display("FAIL midreset_state ready=%b done=%b state=%h want ready=1 done=0 state=0", readyV[1], doneV[1], outV[1]);
    end
    sawDone = 1'b0;
    repeat (12) begin
      tick();
      if (doneV[1] !== 1'b0) sawDone = 1'b1;
    end
    total++;
    if (sawDone) begin bad++; $display("FAIL midreset_no_done got=1 want=0"); end
    st = randState();
    runOp(1, st, res, lat, ok);
    total++;
    if (!ok || lat !== 8 || res !== refLayer(st)) begin
      bad++; $display("FAIL midreset_restart ok=%0d lat=%0d got=%h want=%h", ok, lat, res, refLayer(st));
    end
  endtask

  task automatic test_sweep(input int k, input int nb, input int n);
    logic [4:0][63:0] st, res, want; int lat; bit ok;
    tick();
    for (int i = 0; i < n; i++) begin
      st = randState();
      want = refLayer(st);
      runOp(k, st, res, lat, ok);
      total++;
      if (!ok || lat !== nb) begin
        bad++; $display("FAIL sweep_nb%0d_lat#%0d ok=%0d got=%0d want=%0d", nb, i, ok, lat, nb);
      end
      total++;
      if (res !== want) begin
        bad++; $display("FAIL sweep_nb%0d_res#%0d got=%h want=%h", nb, i, res, want);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      startV[k] = 1'b0;
      inV[k] = '0;
    end
    test_reset();
    test_zero();
    test_ones();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    fork
      test_sweep(0, 1, 1000);
      test_sweep(1, 8, 1000);
      test_sweep(2, 64, 1000);
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
